// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port among NUM_REQ requesters with bounded bursts.
// Latency: same-cycle grant and memory drive; read data tagged by rvalid one cycle after grant.
// Backpressure: losers hold req until gnt; optional MEM_ARB_LOCK_EN adds a lock input that pins the owner.
module mem_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        lock,
`endif
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

    logic               grant_any;
    logic [IDX_W-1:0]   grant_idx;
    logic               keep_owner;

    // First requester strictly after prev, wrapping; prev itself is checked last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                  input logic [IDX_W-1:0]   prev);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(prev) + k) % NUM_REQ;
            if (!found && r[IDX_W'(idx)]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Arbitration: pick the grant for this cycle and the next ownership state.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        grant_any  = 1'b0;
        grant_idx  = '0;
        keep_owner = req[owner_q] && (cnt_q < MAX_CNT);
`ifdef MEM_ARB_LOCK_EN
        if (req[owner_q] && lock[owner_q]) begin
            keep_owner = 1'b1;
        end
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_any = 1'b1;
                    grant_idx = rr_pick(req, last_q);
                    state_d   = BUSY;
                    owner_d   = grant_idx;
                    last_d    = grant_idx;
                    cnt_d     = CNT_W'(1);
                end
            end
            BUSY: begin
                if (keep_owner) begin
                    grant_any = 1'b1;
                    grant_idx = owner_q;
                    // Locked owners run past MAX_BURST; the count pins there.
                    cnt_d     = (cnt_q < MAX_CNT) ? cnt_q + 1'b1 : cnt_q;
                end else if (|req) begin
                    // Searching from owner+1 makes the current owner lowest priority;
                    // a lone owner past its burst is picked again with no bubble.
                    grant_any = 1'b1;
                    grant_idx = rr_pick(req, owner_q);
                    owner_d   = grant_idx;
                    last_d    = grant_idx;
                    cnt_d     = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            grant_any = 1'b0;
        end
    end

    // Grant vector, memory port drive and the read-return tag for next cycle.
    always_comb begin
        gnt       = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_any) begin
            gnt[grant_idx] = 1'b1;
            mem_we         = we[grant_idx];
            mem_addr       = addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            mem_wdata      = wdata[int'(grant_idx)*DATA_W +: DATA_W];
        end
        rvalid_d = gnt & ~we;
    end

    // A read granted just before reset must not surface while reset is held.
    assign rvalid = rst ? '0 : rvalid_q;
    assign rdata  = mem_rdata;

    // State registers with synchronous reset; last starts at NUM_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            last_q   <= IDX_W'(NUM_REQ - 1);
            cnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule
